// File: rtl/tog_pkg.sv
// rtl/tog_pkg.sv - shared parameters and types for the toggle event decoder
package tog_pkg;

   localparam int SYNC_STAGES_DEF = 2;
   localparam int FILT_LEN_DEF    = 2;
   localparam int CNT_W_DEF       = 4;
   localparam int TOTAL_W         = 16;
   localparam int PEND_MAX_DEF    = (1 << CNT_W_DEF) - 1;

   // What the pending counter does on a given cycle.
   typedef enum logic [1:0] {
      CNT_HOLD = 2'd0,
      CNT_INC  = 2'd1,
      CNT_DEC  = 2'd2,
      CNT_DROP = 2'd3
   } cnt_op_e;

endpackage

// File: rtl/tog_sync_filter.sv
// rtl/tog_sync_filter.sv - synchroniser and glitch filter for the toggle line
// Emits the filtered level and a one-cycle strobe whenever that level flips.
module tog_sync_filter
   import tog_pkg::*;
#(
   parameter int SYNC_STAGES = SYNC_STAGES_DEF,
   parameter int FILT_LEN    = FILT_LEN_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic tog_in,
   output logic level,
   output logic edge_stb
);

   localparam int FCNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
   localparam logic [FCNT_W-1:0] FCNT_MAX = FCNT_W'(FILT_LEN - 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [FCNT_W-1:0]      fcnt_q, fcnt_d;
   logic                   level_q, level_d;
   logic                   mismatch;

   always_comb begin
      sync_d   = {sync_q[SYNC_STAGES-2:0], tog_in};
      mismatch = sync_q[SYNC_STAGES-1] ^ level_q;
      fcnt_d   = '0;
      level_d  = level_q;
      edge_stb = 1'b0;
      // The strobe is decoded from registers, so it lines up with the level flip.
      if (mismatch) begin
         if (fcnt_q == FCNT_MAX) begin
            level_d  = ~level_q;
            edge_stb = 1'b1;
         end else begin
            fcnt_d = fcnt_q + FCNT_W'(1);
         end
      end
   end

   always_ff @(negedge clk) begin
      if (rst) begin
         sync_q  <= '0;
         fcnt_q  <= '0;
         level_q <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         fcnt_q  <= fcnt_d;
         level_q <= level_d;
      end
   end

   assign level = level_q;

endmodule

// File: rtl/toggle_event_decoder.sv
// rtl/toggle_event_decoder.sv - turns toggle-line flips into queued, handshaked events
// Pending counter saturates with a sticky overflow; total_cnt wraps.
module toggle_event_decoder
   import tog_pkg::*;
#(
   parameter int SYNC_STAGES = SYNC_STAGES_DEF,
   parameter int FILT_LEN    = FILT_LEN_DEF,
   parameter int CNT_W       = CNT_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               tog_in,
   input  logic               en,
   input  logic               evt_ready,
   input  logic               clr_ovf,
   output logic               evt_valid,
   output logic [CNT_W-1:0]   pending,
   output logic               level,
   output logic               overflow,
   output logic [TOTAL_W-1:0] total_cnt
);

   localparam logic [CNT_W-1:0] PEND_MAX = {CNT_W{1'b1}};

   logic               edge_stb;
   logic               inc, dec;
   cnt_op_e            cnt_op;
   logic [CNT_W-1:0]   pending_q, pending_d;
   logic               overflow_q, overflow_d;
   logic [TOTAL_W-1:0] total_q, total_d;

   tog_sync_filter #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILT_LEN   (FILT_LEN)
   ) u_sync_filter (
      .clk     (clk),
      .rst     (rst),
      .tog_in  (tog_in),
      .level   (level),
      .edge_stb(edge_stb)
   );

   assign evt_valid = (pending_q != '0);
   assign inc       = edge_stb & en;
   assign dec       = evt_valid & evt_ready;

   always_comb begin
      cnt_op = CNT_HOLD;
      if (inc && !dec) begin
         cnt_op = (pending_q == PEND_MAX) ? CNT_DROP : CNT_INC;
      end else if (!inc && dec) begin
         cnt_op = CNT_DEC;
      end
   end

   always_comb begin
      pending_d  = pending_q;
      overflow_d = overflow_q;
      total_d    = total_q;
      if (inc) begin
         total_d = total_q + TOTAL_W'(1);
      end
      if (clr_ovf) begin
         overflow_d = 1'b0;
      end
      // A drop in the same cycle as clr_ovf must still leave overflow set.
      case (cnt_op)
         CNT_INC:  pending_d  = pending_q + CNT_W'(1);
         CNT_DEC:  pending_d  = pending_q - CNT_W'(1);
         CNT_DROP: overflow_d = 1'b1;
         default:  pending_d  = pending_q;
      endcase
   end

   always_ff @(negedge clk) begin
      if (rst) begin
         pending_q  <= '0;
         overflow_q <= 1'b0;
         total_q    <= '0;
      end else begin
         pending_q  <= pending_d;
         overflow_q <= overflow_d;
         total_q    <= total_d;
      end
   end

   assign pending   = pending_q;
   assign overflow  = overflow_q;
   assign total_cnt = total_q;

endmodule

// File: tb/tb_toggle_event_decoder.sv
// tb/tb_toggle_event_decoder.sv - self-checking bench for toggle_event_decoder
module tb_toggle_event_decoder;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        tog_in = 1'b0;
   logic        en = 1'b1;
   logic        evt_ready = 1'b0;
   logic        clr_ovf = 1'b0;
   logic        evt_valid;
   logic [3:0]  pending;
   logic        level;
   logic        overflow;
   logic [15:0] total_cnt;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        rst;
      logic        tog;
      logic        en;
      logic        rdy;
      logic        clr;
      logic        valid;
      logic [3:0]  pend;
      logic        lvl;
      logic        ovf;
      logic [15:0] total;
   } vec_t;

   vec_t vecs[17];

   toggle_event_decoder dut (
      .clk      (clk),
      .rst      (rst),
      .tog_in   (tog_in),
      .en       (en),
      .evt_ready(evt_ready),
      .clr_ovf  (clr_ovf),
      .evt_valid(evt_valid),
      .pending  (pending),
      .level    (level),
      .overflow (overflow),
      .total_cnt(total_cnt)
   );

   always #5 clk = ~clk;

   // One falling edge, then return at the rising edge where outputs are stable.
   task automatic tick(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         @(posedge clk);
      end
   endtask

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset(input logic tog_val);
      rst = 1'b1;
      tog_in = tog_val;
      evt_ready = 1'b0;
      clr_ovf = 1'b0;
      tick(2);
      rst = 1'b0;
   endtask

   function automatic vec_t mk(input logic r, t, e, rd, c, v, input logic [3:0] p,
                               input logic l, o, input logic [15:0] tot);
      vec_t x;
      x.rst = r; x.tog = t; x.en = e; x.rdy = rd; x.clr = c;
      x.valid = v; x.pend = p; x.lvl = l; x.ovf = o; x.total = tot;
      return x;
   endfunction

   initial begin
      //             rst tog en rdy clr | valid pend lvl ovf total
      vecs[0]  = mk(1, 1, 1, 0, 0,   0, 0, 0, 0, 0);
      vecs[1]  = mk(1, 1, 1, 0, 0,   0, 0, 0, 0, 0);
      vecs[2]  = mk(0, 1, 1, 0, 0,   0, 0, 0, 0, 0);
      vecs[3]  = mk(0, 1, 1, 0, 0,   0, 0, 0, 0, 0);
      vecs[4]  = mk(0, 1, 1, 0, 0,   0, 0, 0, 0, 0);
      vecs[5]  = mk(0, 1, 1, 0, 0,   1, 1, 1, 0, 1);
      vecs[6]  = mk(0, 1, 1, 1, 0,   0, 0, 1, 0, 1);
      vecs[7]  = mk(0, 0, 1, 0, 0,   0, 0, 1, 0, 1);
      vecs[8]  = mk(0, 0, 1, 0, 0,   0, 0, 1, 0, 1);
      vecs[9]  = mk(0, 0, 1, 0, 0,   0, 0, 1, 0, 1);
      vecs[10] = mk(0, 0, 1, 0, 0,   1, 1, 0, 0, 2);
      vecs[11] = mk(0, 0, 1, 1, 0,   0, 0, 0, 0, 2);
      vecs[12] = mk(0, 1, 1, 0, 0,   0, 0, 0, 0, 2);
      vecs[13] = mk(0, 0, 1, 0, 0,   0, 0, 0, 0, 2);
      vecs[14] = mk(0, 0, 1, 0, 0,   0, 0, 0, 0, 2);
      vecs[15] = mk(0, 0, 1, 0, 1,   0, 0, 0, 0, 2);
      vecs[16] = mk(0, 0, 1, 1, 0,   0, 0, 0, 0, 2);

      for (int i = 0; i < 17; i++) begin
         rst = vecs[i].rst; tog_in = vecs[i].tog; en = vecs[i].en;
         evt_ready = vecs[i].rdy; clr_ovf = vecs[i].clr;
         tick(1);
         chk($sformatf("vec%0d.valid", i), 16'(evt_valid), 16'(vecs[i].valid));
         chk($sformatf("vec%0d.pending", i), 16'(pending), 16'(vecs[i].pend));
         chk($sformatf("vec%0d.level", i), 16'(level), 16'(vecs[i].lvl));
         chk($sformatf("vec%0d.overflow", i), 16'(overflow), 16'(vecs[i].ovf));
         chk($sformatf("vec%0d.total", i), total_cnt, vecs[i].total);
      end
      clr_ovf = 1'b0;
      evt_ready = 1'b0;

      // Single 0->1 flip from a clean reset: visible exactly at the 4th edge.
      do_reset(1'b0);
      en = 1'b1;
      tick(3);
      tog_in = 1'b1;
      tick(3);
      chk("single.valid_at_3", 16'(evt_valid), 16'd0);
      chk("single.level_at_3", 16'(level), 16'd0);
      tick(1);
      chk("single.valid_at_4", 16'(evt_valid), 16'd1);
      chk("single.pending", 16'(pending), 16'd1);
      chk("single.total", total_cnt, 16'd1);

      // Saturation: 16 flips with no consumer.
      do_reset(1'b0);
      for (int i = 0; i < 16; i++) begin
         tog_in = ~tog_in;
         tick(6);
      end
      chk("sat.pending", 16'(pending), 16'd15);
      chk("sat.overflow", 16'(overflow), 16'd1);
      chk("sat.total", total_cnt, 16'd16);
      clr_ovf = 1'b1;
      tick(1);
      clr_ovf = 1'b0;
      chk("sat.clr_overflow", 16'(overflow), 16'd0);
      chk("sat.clr_pending", 16'(pending), 16'd15);

      // Edge and consume in the same cycle at max, then drain.
      tog_in = ~tog_in;
      tick(3);
      evt_ready = 1'b1;
      tick(1);
      chk("simul.pending", 16'(pending), 16'd15);
      chk("simul.overflow", 16'(overflow), 16'd0);
      chk("simul.total", total_cnt, 16'd17);
      tick(14);
      chk("drain.pending_14", 16'(pending), 16'd1);
      tick(1);
      chk("drain.pending_15", 16'(pending), 16'd0);
      tick(2);
      chk("drain.hold_pending", 16'(pending), 16'd0);
      chk("drain.hold_valid", 16'(evt_valid), 16'd0);
      evt_ready = 1'b0;

      // en=0: level follows, nothing is counted.
      do_reset(1'b0);
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tog_in = ~tog_in;
         tick(6);
      end
      chk("en0.level", 16'(level), 16'd1);
      chk("en0.pending", 16'(pending), 16'd0);
      chk("en0.total", total_cnt, 16'd0);
      chk("en0.overflow", 16'(overflow), 16'd0);

      // Reset mid-filter: the flip needs the full latency again afterwards.
      do_reset(1'b0);
      en = 1'b1;
      tick(2);
      tog_in = 1'b1;
      tick(3);
      rst = 1'b1;
      tick(1);
      chk("midrst.level", 16'(level), 16'd0);
      chk("midrst.pending", 16'(pending), 16'd0);
      rst = 1'b0;
      tick(3);
      chk("midrst.level_at_3", 16'(level), 16'd0);
      chk("midrst.valid_at_3", 16'(evt_valid), 16'd0);
      tick(1);
      chk("midrst.level_at_4", 16'(level), 16'd1);
      chk("midrst.pending_at_4", 16'(pending), 16'd1);
      chk("midrst.total_at_4", total_cnt, 16'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
